lvds_frame_rd_sched: RTL
========================

Name: lvds_frame_rd_sched

Overview:
- Read-side scheduler for the LVDS bit-to-byte capture RAM (write port 1 bit/clk, read port 8 bit/clk_m_144).
- Pops frame-length descriptors (captured bit counts, already crossed into the clk_m_144 domain by a first-word-fall-through descriptor FIFO) and sequences one RAM read burst per frame.
- Skips the fixed header bytes, drops runt frames, and emits a framed byte stream with sof/eof.
- Enforces a minimum inter-frame gap so the capture side can safely reuse the RAM.

Parameters:
ADDR_W, 12, RAM read-port byte address width
LEN_W, 15, descriptor bit-count width
RAM_LAT, 2, cycles from ram_rdaddr/ram_rden to valid ram_dout
HDR_BYTES, 14, leading bytes per frame not forwarded (never read)
MIN_BITS, 48, frames with desc_len < MIN_BITS are dropped
IFG_CYC, 8, idle cycles enforced after each frame drains

Ports:
clk_m_144  in  1  read-domain clock; all logic on its rising edge
rst_n  in  1  reset, synchronous, active-low
desc_empty  in  1  descriptor FIFO empty
desc_len  in  LEN_W  FWFT head: frame length in bits; valid while !desc_empty
desc_rd_en  out  1  descriptor pop, one-cycle pulse
ram_rden  out  1  RAM read enable
ram_rdaddr  out  ADDR_W  RAM byte address
ram_dout  in  8  RAM read data; bit0 = earliest received bit
dout  out  8  output byte, bit-reversed from RAM (ram_dout[0] -> dout[7])
dout_vld  out  1  dout valid
dout_sof  out  1  first byte of a frame
dout_eof  out  1  last byte of a frame
busy  out  1  high whenever FSM is not IDLE
short_cnt  out  16  dropped-frame counter, saturates at 16'hFFFF

Behaviour:
- Reset: synchronous, active-low, sampled on clk_m_144. While rst_n=0 on a clock edge: FSM -> IDLE; read pipeline flushed; all outputs 0, including short_cnt. Reset in any state aborts the frame with no eof and no pop. A descriptor still in the FIFO is processed after release.
- nbytes = desc_len >> 3. Trailing partial-byte bits are discarded. Max 4095, so no address wrap is possible.
- Drop condition: desc_len < MIN_BITS, or nbytes <= HDR_BYTES.
- FSM states:
  - IDLE: busy=0. If !desc_empty: desc_rd_en=1 for exactly this cycle, latch desc_len, go CHECK.
  - CHECK (1 cycle): evaluate the drop condition.
    - Drop: short_cnt += 1 (saturating), go IDLE; no RAM access.
    - Otherwise: load addr = HDR_BYTES, go READ.
  - READ: ram_rden=1, ram_rdaddr=addr, addr += 1 each cycle. This covers addresses HDR_BYTES..nbytes-1, contiguous with no bubbles. On the cycle addr == nbytes-1, go DRAIN.
  - DRAIN: ram_rden=0 for RAM_LAT+1 cycles so the pipeline empties, then go GAP.
  - GAP: IFG_CYC cycles, then IDLE.
- desc_rd_en is never asserted outside IDLE and never asserted while desc_empty=1.
- ram_rdaddr holds its last value when ram_rden=0. After reset it is 0.
- Output pipeline: RAM_LAT-deep shift register carrying {rden, first, last} alongside each address.
  - At depth RAM_LAT, ram_dout is registered into dout.
  - dout_vld, dout_sof and dout_eof are registered in the same cycle.
  - Latency: address presented at cycle t -> dout/dout_vld at t+RAM_LAT+1.
- dout_sof marks the byte at address HDR_BYTES; dout_eof marks the byte at address nbytes-1. A one-byte payload asserts both in the same cycle.
- dout/sof/eof are 0 whenever dout_vld=0.
- Back-to-back frames: if the last address of frame N is at cycle t, the first address of frame N+1 is at t+RAM_LAT+IFG_CYC+4 (t+14 with defaults).
- Simultaneous events: descriptor arrival during READ/DRAIN/GAP waits in the FIFO; it is never popped early.

Test Plan:
1. desc_len=160 (20 bytes), RAM byte14=8'h01, byte19=8'hF0
   -> ram_rdaddr 14..19 on 6 consecutive cycles
   -> dout_vld high 6 cycles starting 3 cycles after addr 14
   -> first dout=8'h80 with sof; last dout=8'h0F with eof.
2. desc_len=40
   -> single desc_rd_en pulse, ram_rden never high, short_cnt=1, busy back to 0 after 2 cycles.
3. desc_len=120 -> exactly one output byte with sof=eof=1.
   Then desc_len=119 -> dropped, short_cnt increments.
4. Two 160-bit descriptors queued
   -> frame 2 addr 14 exactly 14 cycles after frame 1 addr 19
   -> exactly one pop per frame, no overlap of dout_vld bursts.
5. desc_len=32767
   -> addresses 14..4094, 4081 contiguous valid bytes, eof on address 4094, no wrap to 0.
6. rst_n=0 asserted mid-READ of a 160-bit frame
   -> next edge: all outputs 0, no eof, no further pop.
   -> After release with one descriptor pending: exactly one full frame is delivered.

Source files
------------

// File: rtl/lvds_frame_rd_sched.sv
// Read-side scheduler for the LVDS capture RAM: pops frame descriptors, reads one
// burst per frame past the header, drops runts and emits a framed byte stream.
module lvds_frame_rd_sched #(
    parameter int ADDR_W    = 12,
    parameter int LEN_W     = 15,
    parameter int RAM_LAT   = 2,
    parameter int HDR_BYTES = 14,
    parameter int MIN_BITS  = 48,
    parameter int IFG_CYC   = 8
) (
    input  logic              clk_m_144,
    input  logic              rst_n,
    input  logic              desc_empty,
    input  logic [LEN_W-1:0]  desc_len,
    output logic              desc_rd_en,
    output logic              ram_rden,
    output logic [ADDR_W-1:0] ram_rdaddr,
    input  logic [7:0]        ram_dout,
    output logic [7:0]        dout,
    output logic              dout_vld,
    output logic              dout_sof,
    output logic              dout_eof,
    output logic              busy,
    output logic [15:0]       short_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]         state_r;
    logic [LEN_W-1:0]   len_r;
    logic [7:0]         cnt_r;
    logic [LEN_W-4:0]   nbytes_s;
    logic [ADDR_W-1:0]  last_addr_s;
    logic               drop_s;
    logic               first_s;
    logic               last_s;
    logic [RAM_LAT-1:0] pipe_vld_r;
    logic [RAM_LAT-1:0] pipe_sof_r;
    logic [RAM_LAT-1:0] pipe_eof_r;

    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    // Frame geometry and tags for the address currently on the RAM port.
    always_comb begin
        nbytes_s    = len_r[LEN_W-1:3];
        last_addr_s = ADDR_W'(nbytes_s) - {{(ADDR_W-1){1'b0}}, 1'b1};
        drop_s      = (len_r < LEN_W'(MIN_BITS)) || (nbytes_s <= (LEN_W-3)'(HDR_BYTES));
        first_s     = ram_rden && (ram_rdaddr == ADDR_W'(HDR_BYTES));
        last_s      = ram_rden && (ram_rdaddr == last_addr_s);
    end

    // Pop is combinational so it lines up with the FWFT head; held off during reset.
    assign desc_rd_en = rst_n && (state_r == S_IDLE) && !desc_empty;
    assign busy       = (state_r != S_IDLE);

    // Frame sequencing FSM; the RAM address register doubles as the burst counter.
    always_ff @(posedge clk_m_144) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            len_r      <= {LEN_W{1'b0}};
            cnt_r      <= 8'd0;
            ram_rden   <= 1'b0;
            ram_rdaddr <= {ADDR_W{1'b0}};
            short_cnt  <= 16'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (!desc_empty) begin
                        len_r   <= desc_len;
                        state_r <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (drop_s) begin
                        if (short_cnt != 16'hFFFF) begin
                            short_cnt <= short_cnt + 16'd1;
                        end
                        state_r <= S_IDLE;
                    end else begin
                        ram_rden   <= 1'b1;
                        ram_rdaddr <= ADDR_W'(HDR_BYTES);
                        state_r    <= S_READ;
                    end
                end
                S_READ: begin
                    if (ram_rdaddr == last_addr_s) begin
                        ram_rden <= 1'b0;
                        cnt_r    <= 8'(RAM_LAT);
                        state_r  <= S_DRAIN;
                    end else begin
                        ram_rdaddr <= ram_rdaddr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                S_DRAIN: begin
                    if (cnt_r == 8'd0) begin
                        cnt_r   <= 8'(IFG_CYC - 1);
                        state_r <= S_GAP;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_r == 8'd0) begin
                        state_r <= S_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                default: begin
                    ram_rden <= 1'b0;
                    state_r  <= S_IDLE;
                end
            endcase
        end
    end

    // Tag pipeline tracks the RAM latency; output stage registers data with its tags.
    always_ff @(posedge clk_m_144) begin
        if (!rst_n) begin
            pipe_vld_r <= {RAM_LAT{1'b0}};
            pipe_sof_r <= {RAM_LAT{1'b0}};
            pipe_eof_r <= {RAM_LAT{1'b0}};
            dout       <= 8'h00;
            dout_vld   <= 1'b0;
            dout_sof   <= 1'b0;
            dout_eof   <= 1'b0;
        end else begin
            for (int i = RAM_LAT - 1; i > 0; i--) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
                pipe_sof_r[i] <= pipe_sof_r[i-1];
                pipe_eof_r[i] <= pipe_eof_r[i-1];
            end
            pipe_vld_r[0] <= ram_rden;
            pipe_sof_r[0] <= first_s;
            pipe_eof_r[0] <= last_s;
            dout_vld      <= pipe_vld_r[RAM_LAT-1];
            dout_sof      <= pipe_vld_r[RAM_LAT-1] && pipe_sof_r[RAM_LAT-1];
            dout_eof      <= pipe_vld_r[RAM_LAT-1] && pipe_eof_r[RAM_LAT-1];
            dout          <= pipe_vld_r[RAM_LAT-1] ? bit_rev8(ram_dout) : 8'h00;
        end
    end

endmodule
